// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: watches pc/gp (and optionally tohost stores) and reports PASS, FAIL or TIMEOUT.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   start            one-cycle arm/re-arm pulse; clears counters and verdict
//   pc, gp           core PC and register x3, compared at full XLEN
//   st_valid/addr/data  data-memory store; only observed when
//                    RISCV_TEST_MONITOR_TOHOST_EN is defined
//   done             high in any terminal state
//   pass/fail/timeout  one-hot verdict while done
//   test_num         failing test number (gp>>1 or tohost>>1), 0 otherwise
//   cycles           saturating count of cycles spent in RUN
//
// Optional feature macro: RISCV_TEST_MONITOR_TOHOST_EN (tohost store detection).
module riscv_test_monitor #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] END_PC         = 'h44,
    parameter int              HOLD_CYCLES    = 2,
    parameter int              TIMEOUT_CYCLES = 5000,
    parameter int              CNT_W          = 32,
    parameter logic [XLEN-1:0] TOHOST_ADDR    = 'h1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  gp,
    input  logic             st_valid,
    input  logic [XLEN-1:0]  st_addr,
    input  logic [XLEN-1:0]  st_data,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [XLEN-1:0]  test_num,
    output logic [CNT_W-1:0] cycles
);
    typedef enum logic [2:0] {IDLE, RUN, PASS, FAIL, TOUT} state_t;

    localparam logic [7:0]       HOLD_MAX = 8'(HOLD_CYCLES);
    localparam logic [7:0]       HOLD_END = 8'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [XLEN-1:0]  ONE      = XLEN'(1);

    state_t           state, state_n;
    logic [7:0]       hold_cnt, hold_n;
    logic [CNT_W-1:0] cycle_cnt, cycle_n;
    logic [XLEN-1:0]  num, num_n;
    logic             pc_hit, end_hit, to_hit, host_hit;
    logic [XLEN-1:0]  host_data;

    assign pc_hit  = pc == END_PC;
    // hold_cnt counts prior consecutive matches, so this cycle is the HOLD_CYCLES-th
    assign end_hit = pc_hit && hold_cnt == HOLD_END;
    assign to_hit  = cycle_cnt == TO_LAST;

`ifdef RISCV_TEST_MONITOR_TOHOST_EN
    // Stores with bit 0 clear are not completion writes and are ignored
    assign host_hit  = st_valid && st_addr == TOHOST_ADDR && st_data[0];
    assign host_data = st_data;
`else
    logic unused_tohost;
    assign unused_tohost = ^{st_valid, st_addr, st_data, TOHOST_ADDR};
    assign host_hit      = 1'b0;
    assign host_data     = '0;
`endif

    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        cycle_n = cycle_cnt;
        num_n   = num;
        if (start) begin
            state_n = RUN;
            hold_n  = '0;
            cycle_n = '0;
            num_n   = '0;
        end else if (state == RUN) begin
            cycle_n = cycle_cnt == CNT_MAX ? cycle_cnt : cycle_cnt + CNT_W'(1);
            hold_n  = !pc_hit ? '0 : hold_cnt == HOLD_MAX ? hold_cnt : hold_cnt + 8'd1;
            // Priority: tohost store, then END_PC hold, then timeout
            if (host_hit) begin
                state_n = host_data == ONE ? PASS : FAIL;
                num_n   = host_data == ONE ? '0 : host_data >> 1;
            end else if (end_hit) begin
                state_n = gp == ONE ? PASS : FAIL;
                num_n   = gp == ONE ? '0 : gp >> 1;
            end else if (to_hit) begin
                state_n = TOUT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            cycle_cnt <= '0;
            num       <= '0;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_n;
            cycle_cnt <= cycle_n;
            num       <= num_n;
        end
    end

    assign pass     = state == PASS;
    assign fail     = state == FAIL;
    assign timeout  = state == TOUT;
    assign done     = pass || fail || timeout;
    assign test_num = num;
    assign cycles   = cycle_cnt;
endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb_riscv_test_monitor: scoreboard bench for riscv_test_monitor verdicts, latency and control.
module tb_riscv_test_monitor;
    localparam int TO = 20;

    typedef struct {
        logic        p;
        logic        f;
        logic        t;
        logic [31:0] num;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 0, rst = 1, start = 0, st_valid = 0;
    logic [31:0] pc = 0, gp = 0, st_addr = 0, st_data = 0;
    logic        done, pass, fail, timeout;
    logic [31:0] test_num, cycles;

    exp_t sb[$];
    exp_t e;
    int   checks = 0, fails = 0;
    logic prev_done = 0;

    riscv_test_monitor #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .gp(gp),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .test_num(test_num), .cycles(cycles)
    );

    always #5 clk = ~clk;

    // Scoreboard: every rising edge of done pops one expected verdict
    always @(negedge clk) begin
        if (done && !prev_done) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got pass=%0b fail=%0b timeout=%0b num=%0d cycles=%0d, required no verdict",
                         pass, fail, timeout, test_num, cycles);
            end else begin
                e = sb.pop_front();
                if ({pass, fail, timeout, test_num, cycles} !== {e.p, e.f, e.t, e.num, e.cyc}) begin
                    fails++;
                    $display("FAIL sb_verdict: got pass=%0b fail=%0b timeout=%0b num=%0d cycles=%0d, required pass=%0b fail=%0b timeout=%0b num=%0d cycles=%0d",
                             pass, fail, timeout, test_num, cycles, e.p, e.f, e.t, e.num, e.cyc);
                end
            end
        end
        prev_done = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({done, pass, fail, timeout, test_num, cycles} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got done=%0b cycles=%0d num=%0d, required all zero", done, cycles, test_num);
        end
        pc = 32'h44;
        gp = 1;
        tick();
        rst = 0;
        repeat (3) tick();
        checks++;
        if ({done, cycles} !== 33'd0) begin
            fails++;
            $display("FAIL idle_ignores: got done=%0b cycles=%0d, required 0 0", done, cycles);
        end
    endtask

    task automatic test_pass();
        int n;
        sb.push_back('{1'b1, 1'b0, 1'b0, 32'd0, 32'd12});
        arm();
        pc = 32'h40;
        repeat (10) tick();
        pc = 32'h44;
        gp = 1;
        wait_done(50, n);
        checks++;
        if (n !== 2) begin
            fails++;
            $display("FAIL pass_latency: got %0d cycles, required 2", n);
        end
    endtask

    task automatic test_fail();
        int n;
        sb.push_back('{1'b0, 1'b1, 1'b0, 32'd5, 32'd12});
        arm();
        pc = 32'h40;
        gp = 1;
        repeat (10) tick();
        pc = 32'h44;
        gp = 32'h0000000B;
        wait_done(50, n);
        checks++;
        if (n !== 2) begin
            fails++;
            $display("FAIL fail_latency: got %0d cycles, required 2", n);
        end
    endtask

    task automatic test_debounce();
        sb.push_back('{1'b1, 1'b0, 1'b0, 32'd0, 32'd4});
        arm();
        pc = 32'h44;
        gp = 1;
        tick();
        pc = 32'h48;
        tick();
        checks++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL debounce_single: got done=%0b, required 0", done);
        end
        pc = 32'h44;
        tick();
        checks++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL debounce_first_of_two: got done=%0b, required 0", done);
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL debounce_hold: got done=%0b, required 1", done);
        end
    endtask

    task automatic test_timeout();
        int n;
        sb.push_back('{1'b0, 1'b0, 1'b1, 32'd0, 32'd20});
        arm();
        pc = 32'h40;
        wait_done(100, n);
        checks++;
        if (n !== TO) begin
            fails++;
            $display("FAIL timeout_latency: got %0d cycles, required %0d", n, TO);
        end
        pc = 32'h44;
        gp = 1;
        repeat (4) tick();
        checks++;
        if ({done, pass, timeout, cycles} !== {1'b1, 1'b0, 1'b1, 32'd20}) begin
            fails++;
            $display("FAIL timeout_sticky: got done=%0b pass=%0b timeout=%0b cycles=%0d, required 1 0 1 20",
                     done, pass, timeout, cycles);
        end
    endtask

    task automatic test_tout_vs_end();
        int n;
        sb.push_back('{1'b1, 1'b0, 1'b0, 32'd0, 32'd20});
        arm();
        pc = 32'h40;
        repeat (TO - 2) tick();
        pc = 32'h44;
        gp = 1;
        wait_done(10, n);
        checks++;
        if (n !== 2) begin
            fails++;
            $display("FAIL tout_vs_end_latency: got %0d cycles, required 2", n);
        end
    endtask

    task automatic test_restart();
        int n;
        sb.push_back('{1'b1, 1'b0, 1'b0, 32'd0, 32'd2});
        arm();
        pc = 32'h44;
        gp = 1;
        tick();
        start = 1;
        tick();
        start = 0;
        checks++;
        if ({done, cycles} !== 33'd0) begin
            fails++;
            $display("FAIL restart_clear: got done=%0b cycles=%0d, required 0 0", done, cycles);
        end
        wait_done(10, n);
        checks++;
        if (n !== 2) begin
            fails++;
            $display("FAIL restart_latency: got %0d cycles, required 2", n);
        end
    endtask

    task automatic test_rearm_abort();
        start = 1;
        tick();
        start = 0;
        checks++;
        if ({done, pass, fail, timeout, test_num, cycles} !== '0) begin
            fails++;
            $display("FAIL rearm_clear: got done=%0b pass=%0b cycles=%0d, required all zero", done, pass, cycles);
        end
        pc = 32'h40;
        repeat (5) tick();
        checks++;
        if (cycles !== 32'd5) begin
            fails++;
            $display("FAIL rearm_counting: got cycles=%0d, required 5", cycles);
        end
        #2 rst = 1;
        #1;
        checks++;
        if ({done, test_num, cycles} !== '0) begin
            fails++;
            $display("FAIL abort_async: got done=%0b cycles=%0d, required 0 0", done, cycles);
        end
        tick();
        rst = 0;
        repeat (3) tick();
        checks++;
        if ({done, cycles} !== 33'd0) begin
            fails++;
            $display("FAIL abort_idle: got done=%0b cycles=%0d, required 0 0", done, cycles);
        end
    endtask

`ifdef RISCV_TEST_MONITOR_TOHOST_EN
    task automatic test_tohost();
        int n;
        sb.push_back('{1'b0, 1'b1, 1'b0, 32'd3, 32'd2});
        arm();
        pc = 32'h40;
        st_valid = 1;
        st_addr = 32'h1000;
        st_data = 6;
        tick();
        checks++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL tohost_even_ignored: got done=%0b, required 0", done);
        end
        st_data = 7;
        wait_done(5, n);
        st_valid = 0;
        checks++;
        if (n !== 1) begin
            fails++;
            $display("FAIL tohost_latency: got %0d cycles, required 1", n);
        end
        sb.push_back('{1'b0, 1'b1, 1'b0, 32'd3, 32'd2});
        arm();
        pc = 32'h44;
        gp = 1;
        tick();
        st_valid = 1;
        wait_done(5, n);
        st_valid = 0;
        checks++;
        if (n !== 1) begin
            fails++;
            $display("FAIL tohost_vs_end_latency: got %0d cycles, required 1", n);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_debounce();
        test_timeout();
        test_tout_vs_end();
        test_restart();
        test_rearm_abort();
`ifdef RISCV_TEST_MONITOR_TOHOST_EN
        test_tohost();
`endif
        repeat (2) tick();
        checks++;
        if (sb.size() !== 0) begin
            fails++;
            $display("FAIL sb_drain: got %0d verdicts outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/riscv_test_monitor.md
Name: riscv_test_monitor

Overview:
- Synthesizable, parametrised successor to the per-test pass/fail check in the riscv-tests benches: watches the core's PC and gp (x3) and decides PASS, FAIL or TIMEOUT.
- Adds end-PC debounce, a cycle-budget timeout, failing-test-number extraction and re-arming, so one instance serves every rv32ui/rv32si test bench.
- Sits beside Core in the bench top; its outputs drive result-file writing and $finish.

Parameters:
- XLEN, 32, width of pc, gp and store data/address.
- END_PC, 32'h44, PC at which the test's terminal loop or ecall sits.
- HOLD_CYCLES, 2, consecutive cycles pc must equal END_PC before deciding; legal range 1..255.
- TIMEOUT_CYCLES, 5000, cycles in RUN before TIMEOUT; must be ≥1.
- CNT_W, 32, width of the cycle counter.
- TOHOST_ADDR, 32'h1000, tohost address; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle arm/re-arm pulse.
- pc  in  XLEN  current core PC.
- gp  in  XLEN  current value of register x3.
- st_valid  in  1  data-memory store strobe.
- st_addr  in  XLEN  store address.
- st_data  in  XLEN  store data.
- done  out  1  test finished; high in PASS, FAIL or TOUT.
- pass  out  1  test passed.
- fail  out  1  test failed.
- timeout  out  1  cycle budget exhausted.
- test_num  out  XLEN  failing test number; 0 otherwise.
- cycles  out  CNT_W  cycles spent in RUN; saturating.

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; hold_cnt=0; cycle_cnt=0. rst asserted mid-run aborts immediately with no verdict.
- States: IDLE, RUN, PASS, FAIL, TOUT. All outputs are registered and decoded from state/regs.
- IDLE: start=1 -> RUN; cycle_cnt=0; hold_cnt=0; test_num=0.
- RUN, each cycle:
  - cycle_cnt += 1, saturating at 2^CNT_W-1.
  - pc==END_PC -> hold_cnt += 1, saturating at HOLD_CYCLES; otherwise hold_cnt=0.
  - End condition: pc==END_PC and hold_cnt==HOLD_CYCLES-1, i.e. the HOLD_CYCLES-th consecutive match.
  - At the end condition, sample gp that cycle:
    - gp==1 -> PASS.
    - Otherwise -> FAIL with test_num = gp>>1 (logical shift). gp==0 gives FAIL with test_num=0.
  - Timeout: cycle_cnt==TIMEOUT_CYCLES-1 with no end condition -> TOUT.
  - Simultaneous end condition and timeout -> the end condition wins.
  - start=1 in RUN restarts: counters cleared, state stays RUN, no decision that cycle.
- Latency: verdict outputs rise on the clock edge after the deciding sample.
- PASS, FAIL and TOUT are sticky: inputs are ignored, cycles is frozen, and the state holds until rst or start.
- start from a terminal state -> RUN with all counters and outputs cleared on that edge.
- Output flags:
  - done = PASS|FAIL|TOUT.
  - Exactly one of pass, fail, timeout is high when done=1; all are 0 otherwise.
- pc and gp are compared at full XLEN; X on an input is not specially handled.

Optional Feature:
- Macro: RISCV_TEST_MONITOR_TOHOST_EN.
- Enabled: in RUN, st_valid=1 with st_addr==TOHOST_ADDR is a decision event:
  - st_data==1 -> PASS.
  - st_data[0]==1 and st_data!=1 -> FAIL with test_num=st_data>>1.
  - st_data[0]==0 -> ignored.
  - A tohost event beats a same-cycle END_PC decision and a same-cycle timeout.
- Disabled: st_valid, st_addr and st_data are left unconnected internally and have no effect; ports remain present.

Test Plan:
- Pass: rst pulse, start; pc=0x40 for 10 cycles, then pc=0x44 with gp=1 held -> pass=1 and done=1 exactly 2 cycles after pc first reaches 0x44; test_num=0; cycles=12.
- Fail: as pass, but gp=0x0000000B at the END_PC hold -> fail=1, test_num=5, pass=0.
- Debounce: pc=0x44 for one cycle, then 0x48, then 0x44 for two cycles with gp=1 -> no verdict after the single-cycle visit; pass only after the two-cycle hold.
- Timeout: TIMEOUT_CYCLES=20, pc never 0x44 -> timeout=1 after cycle 20, cycles=20.
- Timeout vs end: second END_PC match lands on the last budget cycle -> pass, not timeout.
- Re-arm and abort: in PASS, pulse start -> all outputs 0 next edge, state RUN. Assert rst mid-RUN -> outputs 0 asynchronously, state IDLE.
- With TOHOST_EN: st_valid=1, st_addr=0x1000, st_data=7 -> fail, test_num=3. Same cycle as an END_PC decision with gp=1 -> fail wins.
